// File: rtl/seq_logic_pkg.sv
// Shared definitions for the serial front stage that feeds the sequence detector.
//   - state_t : two-state encoding for the serializer FSM (IDLE / SHIFT)
//   - clog2_w : ceil-log2 helper used to size the bit counter
package seq_logic_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Smallest r with 2**r >= n.
    function automatic int clog2_w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   load  : capture din (takes priority over shift)
//   shift : advance one bit toward the serial output
//   din   : parallel word
//   sout  : bit that will be presented next by the owning FSM
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sr;

    // The first bit of a word is driven straight from din by the owner on the
    // load edge, so the register is loaded already advanced by one position;
    // sout then always holds the bit for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= MSB_FIRST ? (din << 1) : (din >> 1);
        end else if (shift) begin
            sr <= MSB_FIRST ? (sr << 1) : (sr >> 1);
        end
    end

    assign sout = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front stage for the downstream zero/sequence detector.
// Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per
// clock with no gap between back-to-back words; parks x_out at IDLE_BIT when
// no word is in flight.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   din       : parallel word, captured only on an accept edge
//   din_valid : upstream has a word on din
//   din_ready : a word can be accepted this cycle (from registered state only)
//   x_out     : registered serial bit
//   x_valid   : registered, high while x_out carries a data bit
//   last      : registered, high while x_out carries the final bit of a word
module bit_serializer
    import seq_logic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             last
);

    localparam int CW = clog2_w(WIDTH);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          first_bit;
    logic          next_bit;

    // Ready while idle or while the final bit is on the line, so a new word
    // can follow the current one with no idle cycle.
    assign din_ready = (state == S_IDLE) || last;
    assign accept    = din_valid && din_ready;
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == S_SHIFT),
        .din   (din),
        .sout  (next_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            x_out   <= IDLE_BIT;
            x_valid <= 1'b0;
            last    <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            state   <= S_SHIFT;
            x_out   <= first_bit;
            x_valid <= 1'b1;
            last    <= 1'b0;
            cnt     <= CW'(WIDTH - 1);
        end else if (state == S_SHIFT) begin
            if (last) begin
                state   <= S_IDLE;
                x_out   <= IDLE_BIT;
                x_valid <= 1'b0;
                last    <= 1'b0;
            end else begin
                x_out <= next_bit;
                cnt   <= cnt - CW'(1);
                // Counter reaches 0 exactly when the WIDTH-th bit goes out;
                // it never decrements past 0 because last ends the word.
                last  <= (cnt == CW'(1));
            end
        end
    end

endmodule
